// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory load/store adapter: access sizes,
// FSM states and the alignment rule used to reject accesses up front.
package dmem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_ILL  = 2'b11;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StAccess = 3'd1,
    StWait   = 3'd2,
    StResp   = 3'd3,
    StFault  = 3'd4
  } state_e;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = addr_lo[0];
      SIZE_WORD: bad = (addr_lo != 2'b00);
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_adapter_if.sv
// CPU request/response and memory port B signals of the load/store adapter.
// slave = the adapter itself, master = the CPU plus memory around it.
interface dmem_adapter_if #(
  parameter int unsigned MEM_ADDR_WIDTH = 8
);
  logic                      cpu_req;
  logic [31:0]               cpu_addr;
  logic                      cpu_we;
  logic [1:0]                cpu_size;
  logic                      cpu_signed;
  logic [31:0]               cpu_wdata;
  logic [31:0]               cpu_rdata;
  logic                      cpu_done;
  logic                      cpu_stall;
  logic                      cpu_misaligned;
  logic                      cpu_bus_err;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]               mem_din;
  logic [3:0]                mem_wr;
  logic                      mem_enable;
  logic [31:0]               mem_dout;
  logic                      mem_ready;

  modport slave (
    input  cpu_req, cpu_addr, cpu_we, cpu_size, cpu_signed, cpu_wdata, mem_dout, mem_ready,
    output cpu_rdata, cpu_done, cpu_stall, cpu_misaligned, cpu_bus_err,
    output mem_addr, mem_din, mem_wr, mem_enable
  );

  modport master (
    output cpu_req, cpu_addr, cpu_we, cpu_size, cpu_signed, cpu_wdata, mem_dout, mem_ready,
    input  cpu_rdata, cpu_done, cpu_stall, cpu_misaligned, cpu_bus_err,
    input  mem_addr, mem_din, mem_wr, mem_enable
  );

endinterface

// File: rtl/dmem_lane_align.sv
// Little-endian byte-lane steering: store write mask and data replication,
// load data right-alignment with zero/sign extension.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_signed,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_dout,
  output logic [3:0]  wmask,
  output logic [31:0] din,
  output logic [31:0] rdata
);

  logic [31:0] shifted;

  always_comb begin
    shifted = mem_dout >> {addr_lo, 3'b000};
    wmask   = 4'b1111;
    din     = wdata;
    rdata   = shifted;
    case (size)
      SIZE_BYTE: begin
        wmask = 4'b0001 << addr_lo;
        din   = {4{wdata[7:0]}};
        rdata = {{24{is_signed & shifted[7]}}, shifted[7:0]};
      end
      SIZE_HALF: begin
        wmask = addr_lo[1] ? 4'b1100 : 4'b0011;
        din   = {2{wdata[15:0]}};
        rdata = {{16{is_signed & shifted[15]}}, shifted[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_adapter.sv
// CPU load/store to word-memory port B adapter: one access per request, 3-cycle latency.
// Define DMEM_TIMEOUT_EN to abort accesses whose mem_ready never arrives with cpu_bus_err.
module dmem_adapter
  import dmem_pkg::*;
#(
  parameter int unsigned MEM_ADDR_WIDTH = 8,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input logic           clk,
  input logic           rst,
  dmem_adapter_if.slave bus
);

  state_e                    state_q, state_d;
  logic [MEM_ADDR_WIDTH+1:0] addr_q;
  logic                      we_q;
  logic [1:0]                size_q;
  logic                      signed_q;
  logic [31:0]               wdata_q;
  logic [31:0]               rdata_q;
  logic                      accept;
  logic                      capture;
  logic                      timeout_hit;
  logic [3:0]                wmask;
  logic [31:0]               din;
  logic [31:0]               ext_rdata;
  logic                      unused_addr_hi;

  assign unused_addr_hi = ^bus.cpu_addr[31:MEM_ADDR_WIDTH+2];

  dmem_lane_align u_align (
    .addr_lo  (addr_q[1:0]),
    .size     (size_q),
    .is_signed(signed_q),
    .wdata    (wdata_q),
    .mem_dout (bus.mem_dout),
    .wmask    (wmask),
    .din      (din),
    .rdata    (ext_rdata)
  );

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.cpu_req) begin
          if (is_misaligned(bus.cpu_size, bus.cpu_addr[1:0])) begin
            state_d = StFault;
          end else begin
            accept  = 1'b1;
            state_d = StAccess;
          end
        end
      end
      StAccess: state_d = StWait;
      StWait: begin
        // A ready arriving in the timeout cycle still completes the access.
        if (bus.mem_ready) begin
          capture = ~we_q;
          state_d = StResp;
        end else if (timeout_hit) begin
          state_d = StResp;
        end
      end
      StResp, StFault: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      we_q     <= 1'b0;
      size_q   <= SIZE_BYTE;
      signed_q <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q   <= bus.cpu_addr[MEM_ADDR_WIDTH+1:0];
        we_q     <= bus.cpu_we;
        size_q   <= bus.cpu_size;
        signed_q <= bus.cpu_signed;
        wdata_q  <= bus.cpu_wdata;
      end
      if (capture) begin
        rdata_q <= ext_rdata;
      end
    end
  end

`ifdef DMEM_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] cnt_q;
  logic            err_q;

  assign timeout_hit = (state_q == StWait) && !bus.mem_ready &&
                       (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_q == StAccess) begin
        cnt_q <= '0;
      end else if (state_q == StWait && !bus.mem_ready) begin
        cnt_q <= cnt_q + 1'b1;
      end
      // RESP is only ever entered from WAIT, so this flag tags its cause.
      if (state_q == StWait) begin
        err_q <= timeout_hit;
      end
    end
  end

  assign bus.cpu_bus_err = (state_q == StResp) && err_q;
`else
  localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;

  assign timeout_hit     = 1'b0;
  assign bus.cpu_bus_err = 1'b0;
`endif

  assign bus.mem_enable     = (state_q == StAccess);
  assign bus.mem_wr         = (state_q == StAccess && we_q) ? wmask : 4'b0000;
  assign bus.mem_addr       = addr_q[MEM_ADDR_WIDTH+1:2];
  assign bus.mem_din        = din;
  assign bus.cpu_rdata      = rdata_q;
  assign bus.cpu_done       = (state_q == StResp) || (state_q == StFault);
  assign bus.cpu_misaligned = (state_q == StFault);
  assign bus.cpu_stall      = bus.cpu_req & ~bus.cpu_done;

endmodule

// File: tb/tb_dmem_adapter.sv
// Randomized bench for dmem_adapter against a byte-array memory model; the
// simulation memory answering port B lives here with an adjustable ready latency.
module tb_dmem_adapter;

  localparam int unsigned AW = 8;
  localparam int unsigned TO = 15;
  localparam int unsigned NWORDS = 1 << AW;

  logic clk;
  logic rst;

  dmem_adapter_if #(.MEM_ADDR_WIDTH(AW)) bus ();

  dmem_adapter #(
    .MEM_ADDR_WIDTH(AW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Simulation memory: registered read data, ready ready_lat cycles after enable (0 = never).
  logic [31:0] mem [NWORDS];
  int          ready_lat;
  int          pend;

  initial pend = 0;
  assign bus.mem_ready = (pend == 1);

  always @(posedge clk) begin
    if (bus.mem_enable) begin
      bus.mem_dout <= mem[bus.mem_addr];
      for (int k = 0; k < 4; k++) begin
        if (bus.mem_wr[k]) mem[bus.mem_addr][8*k +: 8] = bus.mem_din[8*k +: 8];
      end
      pend <= ready_lat;
    end else if (pend != 0) begin
      pend <= pend - 1;
    end
  end

  // Reference model state.
  logic [7:0]  ref_mem [NWORDS*4];
  logic [31:0] exp_rdata;

  int n_checks;
  int n_fail;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic preload(input int w, input logic [31:0] v);
    mem[w] = v;
    for (int k = 0; k < 4; k++) ref_mem[4*w + k] = v[8*k +: 8];
  endtask

  function automatic logic [31:0] ref_load(input int a, input logic [1:0] size, input logic sgn);
    logic [31:0] v;
    int n;
    v = '0;
    n = 1 << size;
    for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[a + i];
    if (sgn && n < 4 && v[8*n-1]) begin
      for (int i = 8 * n; i < 32; i++) v[i] = 1'b1;
    end
    return v;
  endfunction

  task automatic do_access(input logic [31:0] addr, input logic we, input logic [1:0] size,
                           input logic sgn, input logic [31:0] wdata, input bit keep,
                           input string tag);
    int          n, a, cyc, en_cnt, stray_wr, exp_cyc;
    bit          fault, tmo, done_seen;
    logic [3:0]  exp_wr, obs_wr;
    logic [31:0] exp_din, obs_din, obs_rd;
    logic [AW-1:0] obs_maddr;
    logic        mis, berr, stall1;
    n = (size == 2'd3) ? 4 : (1 << size);
    a = int'(addr[AW+1:0]);
    fault = (size == 2'd3) || (a % n != 0);
    tmo = 1'b0;
`ifdef DMEM_TIMEOUT_EN
    tmo = !fault && (ready_lat == 0 || ready_lat > int'(TO));
`endif
    exp_cyc = fault ? 1 : (tmo ? 2 + int'(TO) : 2 + ready_lat);
    exp_wr  = '0;
    exp_din = '0;
    if (!fault) begin
      for (int i = 0; i < n; i++) exp_wr[(a + i) % 4] = 1'b1;
      for (int k = 0; k < 4; k++) exp_din[8*k +: 8] = wdata[8*(k % n) +: 8];
      if (we) begin
        for (int i = 0; i < n; i++) ref_mem[a + i] = wdata[8*i +: 8];
      end else if (!tmo) begin
        exp_rdata = ref_load(a, size, sgn);
      end
    end

    bus.cpu_req    = 1'b1;
    bus.cpu_addr   = addr;
    bus.cpu_we     = we;
    bus.cpu_size   = size;
    bus.cpu_signed = sgn;
    bus.cpu_wdata  = wdata;

    cyc = 0; en_cnt = 0; stray_wr = 0; done_seen = 1'b0;
    stall1 = 1'b0; mis = 1'b0; berr = 1'b0; obs_rd = '0;
    obs_wr = '0; obs_din = '0; obs_maddr = '0;
    while (!done_seen && cyc < 60) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 1) stall1 = bus.cpu_stall;
      if (bus.mem_enable) begin
        en_cnt++;
        obs_wr    = bus.mem_wr;
        obs_din   = bus.mem_din;
        obs_maddr = bus.mem_addr;
      end else if (bus.mem_wr != 4'b0000) begin
        stray_wr++;
      end
      if (bus.cpu_done) begin
        done_seen = 1'b1;
        mis       = bus.cpu_misaligned;
        berr      = bus.cpu_bus_err;
        obs_rd    = bus.cpu_rdata;
        if (!keep) bus.cpu_req = 1'b0;
      end
    end

    if (!done_seen) begin
      check_eq({tag, ".no_done"}, 32'(cyc), 32'(exp_cyc));
      bus.cpu_req = 1'b0;
    end else begin
      check_eq({tag, ".latency"}, 32'(cyc), 32'(exp_cyc));
      check_eq({tag, ".misaligned"}, 32'(mis), 32'(fault));
      check_eq({tag, ".bus_err"}, 32'(berr), 32'(tmo));
      check_eq({tag, ".enables"}, 32'(en_cnt), fault ? 32'd0 : 32'd1);
      check_eq({tag, ".stray_wr"}, 32'(stray_wr), 32'd0);
      check_eq({tag, ".stall1"}, 32'(stall1), 32'(!fault));
      check_eq({tag, ".rdata"}, obs_rd, exp_rdata);
      if (!fault) begin
        check_eq({tag, ".mem_addr"}, 32'(obs_maddr), 32'(addr[AW+1:2]));
        check_eq({tag, ".mem_wr"}, 32'(obs_wr), we ? 32'(exp_wr) : 32'd0);
        if (we) check_eq({tag, ".mem_din"}, obs_din, exp_din);
      end
    end
    @(posedge clk);
    #1;
    check_eq({tag, ".done_pulse"}, 32'(bus.cpu_done), 32'd0);
  endtask

  int bad_words;
  int done_cnt;

  initial begin
    logic [31:0] addr;
    logic [1:0]  size;
    n_checks  = 0;
    n_fail    = 0;
    exp_rdata = '0;
    ready_lat = 1;
    for (int w = 0; w < int'(NWORDS); w++) preload(w, $urandom);

    rst            = 1'b0;
    bus.cpu_req    = 1'b0;
    bus.cpu_addr   = '0;
    bus.cpu_we     = 1'b0;
    bus.cpu_size   = 2'b00;
    bus.cpu_signed = 1'b0;
    bus.cpu_wdata  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst.done", 32'(bus.cpu_done), 32'd0);
    check_eq("rst.misaligned", 32'(bus.cpu_misaligned), 32'd0);
    check_eq("rst.bus_err", 32'(bus.cpu_bus_err), 32'd0);
    check_eq("rst.mem_enable", 32'(bus.mem_enable), 32'd0);
    check_eq("rst.mem_wr", 32'(bus.mem_wr), 32'd0);
    check_eq("rst.mem_addr", 32'(bus.mem_addr), 32'd0);
    check_eq("rst.mem_din", bus.mem_din, 32'd0);
    check_eq("rst.rdata", bus.cpu_rdata, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Directed cases.
    preload(4, 32'hDEADBEEF);
    do_access(32'h10, 1'b0, 2'b10, 1'b0, 32'h0, 1'b0, "ld_word");
    check_eq("tp.word", bus.cpu_rdata, 32'hDEADBEEF);
    preload(4, 32'h80FF1234);
    do_access(32'h13, 1'b0, 2'b00, 1'b1, 32'h0, 1'b0, "ld_sbyte");
    check_eq("tp.sbyte", bus.cpu_rdata, 32'hFFFFFF80);
    do_access(32'h13, 1'b0, 2'b00, 1'b0, 32'h0, 1'b0, "ld_ubyte");
    check_eq("tp.ubyte", bus.cpu_rdata, 32'h00000080);
    do_access(32'h22, 1'b1, 2'b01, 1'b0, 32'h1234ABCD, 1'b0, "st_half");
    check_eq("tp.st_hold", bus.cpu_rdata, 32'h00000080);
    do_access(32'h22, 1'b0, 2'b01, 1'b0, 32'h0, 1'b0, "ld_half");
    check_eq("tp.half", bus.cpu_rdata, 32'h0000ABCD);
    do_access(32'h06, 1'b0, 2'b10, 1'b0, 32'h0, 1'b0, "mis_word");
    do_access(32'h41, 1'b1, 2'b01, 1'b0, 32'h5555, 1'b0, "mis_half");
    do_access(32'h40, 1'b0, 2'b11, 1'b0, 32'h0, 1'b0, "ill_size");

`ifdef DMEM_TIMEOUT_EN
    ready_lat = 0;
    do_access(32'h80, 1'b0, 2'b10, 1'b0, 32'h0, 1'b0, "timeout");
    ready_lat = int'(TO);
    do_access(32'h84, 1'b0, 2'b10, 1'b0, 32'h0, 1'b0, "ready_at_limit");
`else
    ready_lat = 20;
    do_access(32'h80, 1'b0, 2'b10, 1'b0, 32'h0, 1'b0, "slow_mem");
`endif
    ready_lat = 1;
    do_access(32'h88, 1'b0, 2'b10, 1'b0, 32'h0, 1'b0, "after_slow");

    // Reset while in WAIT with a late ready still pending.
    ready_lat = 3;
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 32'h0C;
    bus.cpu_we   = 1'b0;
    bus.cpu_size = 2'b10;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst         = 1'b0;
    bus.cpu_req = 1'b0;
    @(posedge clk);
    #1;
    rst       = 1'b1;
    exp_rdata = '0;
    check_eq("mid_rst.done", 32'(bus.cpu_done), 32'd0);
    check_eq("mid_rst.mem_enable", 32'(bus.mem_enable), 32'd0);
    check_eq("mid_rst.mem_addr", 32'(bus.mem_addr), 32'd0);
    check_eq("mid_rst.mem_din", bus.mem_din, 32'd0);
    check_eq("mid_rst.rdata", bus.cpu_rdata, 32'd0);
    done_cnt = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (bus.cpu_done) done_cnt++;
    end
    check_eq("mid_rst.late_ready", 32'(done_cnt), 32'd0);
    ready_lat = 1;
    do_access(32'h0C, 1'b0, 2'b10, 1'b0, 32'h0, 1'b0, "post_rst");

    // Random traffic, sometimes holding cpu_req across back-to-back accesses.
    for (int it = 0; it < 200; it++) begin
      addr = $urandom;
      size = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      if ($urandom_range(0, 9) < 7) begin
        if (size == 2'b01) addr[0] = 1'b0;
        if (size == 2'b10) addr[1:0] = 2'b00;
      end
      ready_lat = $urandom_range(1, 4);
      do_access(addr, 1'($urandom_range(0, 1)), size, 1'($urandom_range(0, 1)), $urandom,
                1'($urandom_range(0, 1)), "rand");
    end
    bus.cpu_req = 1'b0;

    bad_words = 0;
    for (int w = 0; w < int'(NWORDS); w++) begin
      if (mem[w] !== {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]}) begin
        bad_words++;
      end
    end
    check_eq("mem_image", 32'(bad_words), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_adapter.md
# dmem_adapter

CPU-side load/store adapter that drives port B of the dual-port simulation memory. It converts a byte-addressed load/store request (byte/half/word, signed/unsigned) into one word-addressed memory access with byte-lane write mask, waits for the memory's registered ready, and returns aligned, extended read data with a single-cycle completion pulse. It flags misaligned accesses without touching memory and, optionally, aborts hung accesses with a bus error.

## Interface
- MEM_ADDR_WIDTH, 8, word-address width of the memory port
- TIMEOUT_CYCLES, 15, WAIT cycles before bus error (used only with DMEM_TIMEOUT_EN)
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-low
- cpu_req  in  1  request; held by CPU until cpu_done
- cpu_addr  in  32  byte address
- cpu_we  in  1  1 = store, 0 = load
- cpu_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- cpu_signed  in  1  sign-extend loads
- cpu_wdata  in  32  store data, right-justified
- cpu_rdata  out  32  load result, valid with cpu_done
- cpu_done  out  1  one-cycle completion pulse
- cpu_stall  out  1  cpu_req & ~cpu_done (combinational)
- cpu_misaligned  out  1  one-cycle pulse with cpu_done, address/size fault
- cpu_bus_err  out  1  one-cycle pulse with cpu_done, timeout fault
- mem_addr  out  MEM_ADDR_WIDTH  cpu_addr[MEM_ADDR_WIDTH+1:2], latched
- mem_din  out  32  lane-replicated store data
- mem_wr  out  4  byte write mask; 0000 for loads
- mem_enable  out  1  access strobe, exactly one cycle per access
- mem_dout  in  32  memory read data
- mem_ready  in  1  memory ready (registered copy of mem_enable)

## Operation
- States: IDLE, ACCESS, WAIT, RESP, FAULT.
- IDLE: cpu_req & aligned -> latch addr/we/size/signed/wdata, go ACCESS; cpu_req & fault -> FAULT; else stay.
- Fault: size 11, half with addr[0]=1, word with addr[1:0]!=0. No memory access.
- ACCESS: mem_enable=1, mem_wr=mask (stores), -> WAIT.
- WAIT: mem_enable=0, mem_wr=0; on mem_ready capture extracted load data into cpu_rdata -> RESP.
- RESP: cpu_done=1 -> IDLE. FAULT: cpu_done=1, cpu_misaligned=1 -> IDLE.
- Lanes little-endian: byte k=addr[1:0] -> mask 1<<k, din {4{wdata[7:0]}}; half h=addr[1] -> mask 0011/1100, din {2{wdata[15:0]}}; word -> 1111, din wdata.
- Load extract: shift mem_dout right by 8*addr[1:0]; byte/half zero- or sign-extended per cpu_signed; word unchanged.
- Stores: cpu_rdata holds previous value; cpu_done still pulses.
- mem_ready in IDLE/ACCESS/RESP/FAULT ignored.

## Timing
- Reset (rst=0 at edge): state IDLE; cpu_rdata=0, cpu_done=0, cpu_misaligned=0, cpu_bus_err=0, mem_enable=0, mem_wr=0, mem_addr=0, mem_din=0, counter=0.
- Access latency: req sampled edge 0, mem_enable cycle 1, mem_ready cycle 2, cpu_done cycle 3 (3 cycles).
- Fault latency: cpu_done+cpu_misaligned in cycle 1.
- cpu_req still high in the cycle after cpu_done is a new request.
- Reset mid-access aborts; no cpu_done; a late mem_ready is ignored.
- Back-to-back accesses: one every 4 cycles.

## Configuration
- DMEM_TIMEOUT_EN defined: counter cleared on entering WAIT, increments each WAIT cycle without mem_ready; reaching TIMEOUT_CYCLES -> RESP with cpu_bus_err=1, cpu_rdata unchanged. mem_ready in the same cycle wins.
- Undefined: WAIT waits forever; cpu_bus_err tied 0; no counter logic.

## Structure
- Package dmem_pkg: size encodings (SIZE_BYTE, SIZE_HALF, SIZE_WORD), state encoding localparams.
- Sub-module dmem_lane_align (combinational): write mask, store replication, load extract/extend.

## Test plan
- Word load addr 0x10, mem word 4 = 0xDEADBEEF -> mem_enable cycle 1, cpu_rdata=0xDEADBEEF with cpu_done cycle 3.
- Signed byte load addr 0x13 of 0x80FF1234 -> cpu_rdata=0xFFFFFF80; unsigned -> 0x00000080.
- Half store 0xABCD to addr 0x22 -> mem_wr=1100, mem_din=0xABCDABCD, mem_addr=8; readback half-unsigned = 0x0000ABCD.
- Word load addr 0x06 -> cpu_misaligned+cpu_done in cycle 1, mem_enable never asserted.
- DMEM_TIMEOUT_EN, mem_ready forced 0 -> cpu_bus_err+cpu_done after 15 WAIT cycles; then normal access succeeds.
- rst=0 during WAIT -> all outputs 0 next cycle, no cpu_done; following request completes normally.
